// File: rtl/router_pkg.sv
// Shared router definitions: widths, FIFO geometry, header field layout and the
// stored FIFO word type.
package router_pkg;

    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_ADDR_W = 4;

    // Header byte layout: destination port in [1:0], payload length in [7:2].
    localparam int HDR_DEST_LSB = 0;
    localparam int HDR_DEST_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    typedef struct packed {
        logic              hdr;
        logic [DATA_W-1:0] data;
    } fifo_word_t;

    function automatic logic [HDR_LEN_MSB-HDR_LEN_LSB:0] hdr_length(input logic [DATA_W-1:0] hdr_byte);
        return hdr_byte[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Dual-port register array for router_fifo: synchronous write, combinational read.
// Contents are deliberately not reset.
module router_fifo_mem #(
    parameter int WORD_W = 9,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-output-port packet FIFO with header-marker tracking and packet-drain status.
// Optional occupancy output fifo_count is enabled by defining ROUTER_FIFO_OCC_EN.
module router_fifo #(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = router_pkg::FIFO_DEPTH,
    parameter int ADDR_W = router_pkg::FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
`ifdef ROUTER_FIFO_OCC_EN
    output logic [ADDR_W:0]   fifo_count,
`endif
    output logic              pkt_active
);
    import router_pkg::*;

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wr_ptr_r;
    logic [ADDR_W:0] rd_ptr_r;
    logic [5:0]      pkt_cnt_r;
    logic            do_wr_s;
    logic            do_rd_s;
    fifo_word_t      wr_word_s;
    fifo_word_t      rd_word_s;

    assign empty      = (wr_ptr_r == rd_ptr_r);
    assign full       = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                        (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
    assign pkt_active = (pkt_cnt_r != 6'd0);

`ifdef ROUTER_FIFO_OCC_EN
    assign fifo_count = wr_ptr_r - rd_ptr_r;
`endif

    // Both requests are qualified by the pre-edge flags, so full favours the read
    // and empty favours the write when they collide.
    assign do_wr_s   = write_enb && !full;
    assign do_rd_s   = read_enb && !empty;
    assign wr_word_s = '{hdr: lfd_state, data: data_in};

    router_fifo_mem #(
        .WORD_W (DATA_W + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (do_wr_s && !soft_reset),
        .waddr (wr_ptr_r[ADDR_W-1:0]),
        .wdata (wr_word_s),
        .raddr (rd_ptr_r[ADDR_W-1:0]),
        .rdata (rd_word_s)
    );

    // Pointer, read-data and packet-counter state; flush outranks any access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            pkt_cnt_r <= 6'd0;
            data_out  <= '0;
        end else if (soft_reset) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            pkt_cnt_r <= 6'd0;
            data_out  <= '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_rd_s) begin
                data_out <= rd_word_s.data;
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                // Header reload counts payload bytes plus the trailing parity byte.
                if (rd_word_s.hdr) begin
                    pkt_cnt_r <= hdr_length(rd_word_s.data) + 6'd1;
                end else if (pkt_cnt_r != 6'd0) begin
                    pkt_cnt_r <= pkt_cnt_r - 6'd1;
                end else begin
                    pkt_cnt_r <= 6'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo (fill/drain, packet tracking,
// collisions, flush and async reset).
module tb_router_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_active;
`ifdef ROUTER_FIFO_OCC_EN
    logic [4:0] fifo_count;
`endif

    int checks   = 0;
    int failures = 0;

    router_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
`ifdef ROUTER_FIFO_OCC_EN
        .fifo_count (fifo_count),
`endif
        .pkt_active (pkt_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic hdr);
        write_enb = 1'b1;
        lfd_state = hdr;
        data_in   = b;
        tick();
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        chk(tag, {24'd0, data_out}, {24'd0, exp});
    endtask

    initial begin
        reset      = 1'b1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;

        // Reset state
        #2;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_pkt_active", {31'd0, pkt_active}, 32'd0);
        chk("rst_data_out", {24'd0, data_out}, 32'h00);
        #10;
        reset = 1'b0;
        tick();

        // Fill to capacity with 0x01..0x10
        write_enb = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            data_in = 8'(i);
            tick();
            if (i == 15) chk("full_at_15", {31'd0, full}, 32'd0);
        end
        chk("full_at_16", {31'd0, full}, 32'd1);
`ifdef ROUTER_FIFO_OCC_EN
        chk("occ_full", {27'd0, fifo_count}, 32'd16);
`endif
        data_in = 8'hFF;
        tick();
        write_enb = 1'b0;
        chk("full_after_drop", {31'd0, full}, 32'd1);
        read_enb = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("drain_order", {24'd0, data_out}, 32'(i));
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);
        tick();
        read_enb = 1'b0;
        chk("read_empty_hold", {24'd0, data_out}, 32'h10);

        // Packet tracking: header 0x0C -> length 3, plus parity
        push(8'h0C, 1'b1);
        push(8'hA1, 1'b0);
        push(8'hA2, 1'b0);
        push(8'hA3, 1'b0);
        push(8'h5E, 1'b0);
        chk("pkt_idle", {31'd0, pkt_active}, 32'd0);
        pop("pkt_hdr", 8'h0C);
        chk("pkt_active_hdr", {31'd0, pkt_active}, 32'd1);
        pop("pkt_a1", 8'hA1);
        pop("pkt_a2", 8'hA2);
        pop("pkt_a3", 8'hA3);
        chk("pkt_active_a3", {31'd0, pkt_active}, 32'd1);
        pop("pkt_parity", 8'h5E);
        chk("pkt_active_end", {31'd0, pkt_active}, 32'd0);
        chk("pkt_empty", {31'd0, empty}, 32'd1);

        // Full with simultaneous read and write
        write_enb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = 8'h20 + 8'(i);
            tick();
        end
        chk("full2", {31'd0, full}, 32'd1);
        data_in  = 8'h99;
        read_enb = 1'b1;
        tick();
        write_enb = 1'b0;
        chk("rw_full_data", {24'd0, data_out}, 32'h20);
        chk("rw_full_deassert", {31'd0, full}, 32'd0);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("rw_full_drain", {24'd0, data_out}, 32'h20 + 32'(i));
        end
        read_enb = 1'b0;
        chk("rw_full_empty", {31'd0, empty}, 32'd1);

        // Empty with simultaneous read and write: write wins, read ignored
        write_enb = 1'b1;
        read_enb  = 1'b1;
        data_in   = 8'h77;
        tick();
        write_enb = 1'b0;
        read_enb  = 1'b0;
        chk("rw_empty_hold", {24'd0, data_out}, 32'h2F);
        chk("rw_empty_notempty", {31'd0, empty}, 32'd0);
        pop("rw_empty_read", 8'h77);

        // Soft reset flush with 5 entries queued and a write in the same cycle
        for (int i = 0; i < 5; i++) push(8'h31 + 8'(i), 1'b0);
        push(8'h0C, 1'b1);
        pop("pre_flush_first", 8'h31);
        soft_reset = 1'b1;
        write_enb  = 1'b1;
        data_in    = 8'h66;
        tick();
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        chk("flush_empty", {31'd0, empty}, 32'd1);
        chk("flush_full", {31'd0, full}, 32'd0);
        chk("flush_data_out", {24'd0, data_out}, 32'h00);
        chk("flush_pkt_active", {31'd0, pkt_active}, 32'd0);
`ifdef ROUTER_FIFO_OCC_EN
        chk("flush_occ", {27'd0, fifo_count}, 32'd0);
`endif
        pop("flush_read_empty", 8'h00);
        push(8'h44, 1'b0);
        pop("post_flush_read", 8'h44);
        chk("post_flush_empty", {31'd0, empty}, 32'd1);

        // Async reset mid-packet
        push(8'h10, 1'b1);
        push(8'hB1, 1'b0);
        push(8'hB2, 1'b0);
        pop("ar_hdr", 8'h10);
        chk("ar_pkt_active", {31'd0, pkt_active}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_empty", {31'd0, empty}, 32'd1);
        chk("ar_pkt_inactive", {31'd0, pkt_active}, 32'd0);
        chk("ar_data_out", {24'd0, data_out}, 32'h00);
        #3;
        reset = 1'b0;
        pop("ar_read_after", 8'h00);
        chk("ar_still_empty", {31'd0, empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
